// File: rtl/imem_prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   IMEM_ADDR_W : default instruction-memory word-address width (also used by TopLevel)
//   IMEM_DATA_W : default instruction word width
//   state_e     : loader FSM state encoding
package imem_prog_loader_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

    localparam int HOLD_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_prog_loader_if.sv
// Bus between a program source (testbench or UART front-end) and the loader,
// plus the loader's memory-write, core-control and status outputs.
//   master : program source; drives start/load_len/in_valid/in_data
//   slave  : loader; drives in_ready, imem write port, core_reset and status
interface imem_prog_loader_if
    import imem_prog_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);

    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W:0]   word_count;

    modport master (
        output start, load_len, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  core_reset, busy, done, error, checksum, word_count
    );

    modport slave (
        input  start, load_len, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output core_reset, busy, done, error, checksum, word_count
    );

endinterface

// File: rtl/imem_prog_loader.sv
// Instruction-memory program loader. Accepts a stream of instruction words
// over a valid/ready handshake, writes them to instruction memory from word 0
// upward, holds the core in reset while loading and releases it after a
// fixed flush delay.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus_if : slave side of imem_prog_loader_if (handshake, imem write port,
//            core_reset, busy/done/error, checksum, word_count)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | after reset; core held in reset, waiting for a valid start
// ST_LOAD | in_ready high, accepting words until load_len reached
// ST_HOLD | core still in reset for HOLD_CYCLES cycles (pipeline flush)
// ST_RUN  | core released; a valid start reloads a new program
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DATA_W      = IMEM_DATA_W,
    parameter int HOLD_CYCLES = 3
) (
    input logic                clk,
    input logic                reset,
    imem_prog_loader_if.slave  bus_if
);

    localparam logic [ADDR_W:0]     MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]     CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [ADDR_W:0]        len_q, len_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]      sum_q, sum_d;
    logic [HOLD_CNT_W-1:0]  hold_q, hold_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   len_ok;

    assign len_ok = (bus_if.load_len != '0) && (bus_if.load_len <= MAX_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        err_d   = err_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus_if.start) begin
                    if (len_ok) begin
                        state_d = ST_LOAD;
                        len_d   = bus_if.load_len;
                        cnt_d   = '0;
                        sum_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // in_ready is exactly (state_q == ST_LOAD), so in_valid alone
                // decides the accept here. cnt_q < len_q <= 2**ADDR_W, so the
                // truncated address never wraps within a load.
                if (bus_if.in_valid) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = bus_if.in_data;
                    cnt_d   = cnt_q + CNT_ONE;
                    sum_d   = sum_q + bus_if.in_data;
                    if (cnt_d == len_q) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs are registers or decodes of registered state only.
    assign bus_if.in_ready   = (state_q == ST_LOAD);
    assign bus_if.core_reset = (state_q != ST_RUN);
    assign bus_if.busy       = (state_q == ST_LOAD) || (state_q == ST_HOLD);
    assign bus_if.done       = done_q;
    assign bus_if.error      = err_q;
    assign bus_if.checksum   = sum_q;
    assign bus_if.word_count = cnt_q;
    assign bus_if.imem_we    = we_q;
    assign bus_if.imem_addr  = addr_q;
    assign bus_if.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Scoreboard bench for imem_prog_loader: a behavioural model pushes expected
// memory writes into a queue and a negedge monitor pops and compares them.
module tb_imem_prog_loader;
    import imem_prog_loader_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int HOLD  = 3;
    localparam int DEPTH = 1 << AW;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    imem_prog_loader #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(HOLD)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    int checks = 0;
    int errors = 0;

    wr_t exp_q[$];
    logic [DW-1:0] prog[$];

    int          m_phase = P_IDLE;
    int          m_len   = 0;
    int          m_cnt   = 0;
    int          m_hold  = 0;
    logic [DW-1:0] m_sum = '0;
    bit          m_err   = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_acc   = 1'b0;

    int tick_n    = 0;
    int last_done = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour applied at each rising edge, from the inputs present there.
    task automatic model_edge();
        int len;
        m_done = 1'b0;
        m_acc  = 1'b0;
        len    = int'(bus_if.load_len);
        if (reset) begin
            m_phase = P_IDLE;
            m_cnt   = 0;
            m_sum   = '0;
            m_err   = 1'b0;
            exp_q.delete();
        end else if (m_phase == P_LOAD) begin
            if (bus_if.in_valid) begin
                m_acc = 1'b1;
                exp_q.push_back('{addr: AW'(m_cnt), data: bus_if.in_data});
                m_sum = m_sum + bus_if.in_data;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_phase = P_HOLD;
                    m_hold  = HOLD;
                end
            end
        end else if (m_phase == P_HOLD) begin
            m_hold--;
            if (m_hold == 0) begin
                m_phase = P_RUN;
                m_done  = 1'b1;
            end
        end else if (bus_if.start) begin
            if (len >= 1 && len <= DEPTH) begin
                m_phase = P_LOAD;
                m_len   = len;
                m_cnt   = 0;
                m_sum   = '0;
                m_err   = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        tick_n++;
        if (bus_if.done === 1'b1) last_done = tick_n;
        chk("in_ready",   bus_if.in_ready,   m_phase == P_LOAD);
        chk("core_reset", bus_if.core_reset, m_phase != P_RUN);
        chk("busy",       bus_if.busy,       m_phase == P_LOAD || m_phase == P_HOLD);
        chk("done",       bus_if.done,       m_done);
        chk("error",      bus_if.error,      m_err);
        chk("checksum",   bus_if.checksum,   m_sum);
        chk("word_count", bus_if.word_count, m_cnt);
    endtask

    always @(negedge clk) begin
        if (bus_if.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("imem_we_unexpected", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("imem_addr",  bus_if.imem_addr,  e.addr);
                chk("imem_wdata", bus_if.imem_wdata, e.data);
            end
        end
    end

    task automatic start_load(input int len);
        bus_if.start    = 1'b1;
        bus_if.load_len = (AW + 1)'(len);
        tick();
        bus_if.start    = 1'b0;
    endtask

    // vmode 0: in_valid held high; 1: random in_valid with stray starts.
    task automatic feed(input int vmode);
        int guard = 0;
        while (prog.size() > 0 && guard < 4000) begin
            bus_if.in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 99) < 65);
            bus_if.in_data  = bus_if.in_valid ? prog[0] : $urandom();
            if (vmode == 1 && $urandom_range(0, 9) == 0) begin
                bus_if.start    = 1'b1;
                bus_if.load_len = (AW + 1)'($urandom_range(0, 511));
            end
            tick();
            bus_if.start = 1'b0;
            if (m_acc) void'(prog.pop_front());
            guard++;
        end
        bus_if.in_valid = 1'b0;
        if (guard >= 4000) chk("feed_timeout", 1, 0);
    endtask

    task automatic wait_run();
        int guard = 0;
        while (m_phase != P_RUN && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) chk("run_timeout", 1, 0);
    endtask

    initial begin
        int t0;
        int pat[9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};

        reset           = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.load_len = '0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        repeat (3) tick();
        chk("reset_imem_addr",  bus_if.imem_addr,  0);
        chk("reset_imem_wdata", bus_if.imem_wdata, 0);
        chk("reset_imem_we",    bus_if.imem_we,    0);
        reset = 1'b0;
        tick();

        // Basic load of four fixed words.
        prog = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};
        t0 = tick_n;
        start_load(4);
        feed(0);
        wait_run();
        chk("basic_checksum", bus_if.checksum, 32'h0110836C);
        chk("basic_done_latency", last_done - t0, 1 + 4 + HOLD);
        repeat (3) tick();

        // Backpressure with a fixed in_valid pattern, extra valid words refused.
        prog = '{$urandom(), $urandom(), $urandom(), $urandom()};
        start_load(4);
        foreach (pat[i]) begin
            bus_if.in_valid = pat[i][0];
            bus_if.in_data  = (prog.size() > 0) ? prog[0] : $urandom();
            tick();
            if (m_acc) void'(prog.pop_front());
        end
        bus_if.in_valid = 1'b0;
        chk("bp_word_count", bus_if.word_count, 4);
        wait_run();

        // Bad lengths while running; then a good one clears error.
        start_load(0);
        chk("bad0_error", bus_if.error, 1);
        chk("bad0_core_reset", bus_if.core_reset, 0);
        start_load(DEPTH + 1);
        chk("bad257_error", bus_if.error, 1);
        tick();
        prog = '{$urandom()};
        start_load(1);
        chk("good_clears_error", bus_if.error, 0);
        feed(0);
        wait_run();

        // Reload from RUN with two words.
        prog = '{$urandom(), $urandom()};
        start_load(2);
        chk("reload_core_reset", bus_if.core_reset, 1);
        feed(1);
        wait_run();

        // Reset after two of four words.
        prog = '{$urandom(), $urandom(), $urandom(), $urandom()};
        start_load(4);
        bus_if.in_valid = 1'b1;
        repeat (2) begin
            bus_if.in_data = prog.pop_front();
            tick();
        end
        reset = 1'b1;
        bus_if.in_data = prog.pop_front();
        tick();
        chk("midrst_imem_we", bus_if.imem_we, 0);
        chk("midrst_word_count", bus_if.word_count, 0);
        reset = 1'b0;
        bus_if.in_valid = 1'b0;
        prog.delete();
        tick();

        // Bad length from IDLE keeps IDLE, then a full-depth load.
        start_load(0);
        chk("idle_bad_core_reset", bus_if.core_reset, 1);
        tick();
        for (int i = 0; i < DEPTH; i++) prog.push_back($urandom());
        t0 = tick_n;
        start_load(DEPTH);
        feed(0);
        wait_run();
        chk("full_word_count", bus_if.word_count, DEPTH);
        chk("full_done_latency", last_done - t0, 1 + DEPTH + HOLD);

        // Randomized reloads, some preceded by an illegal length.
        for (int r = 0; r < 6; r++) begin
            int len;
            if ($urandom_range(0, 2) == 0) begin
                start_load(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 511));
                tick();
            end
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) prog.push_back($urandom());
            start_load(len);
            feed(1);
            wait_run();
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
